// File: rtl/fp32_adder_if.sv
// Operand and result bundle for the binary32 adder.
// The driver of the operands uses master; the adder uses slave.
interface fp32_adder_if;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output data1,
        output data2,
        input  result,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  data1,
        input  data2,
        output result,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fp32_adder.sv
// IEEE-754 binary32 adder: single combinational align/add/normalize/round stage
// followed by one output register. Subnormals are treated as zero on input and flushed on output.
module fp32_adder (
    input  logic        clk,
    input  logic        rst,
    fp32_adder_if.slave bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (found || v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic        sa_s, sb_s;
    logic [7:0]  ea_s, eb_s;
    logic [22:0] fa_s, fb_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

    assign sa_s     = bus.data1[31];
    assign sb_s     = bus.data2[31];
    assign ea_s     = bus.data1[30:23];
    assign eb_s     = bus.data2[30:23];
    assign fa_s     = bus.data1[22:0];
    assign fb_s     = bus.data2[22:0];
    assign a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
    assign b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
    assign a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
    assign b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
    assign a_zero_s = (ea_s == 8'h00);
    assign b_zero_s = (eb_s == 8'h00);

    logic        swap_s, sl_s;
    logic [7:0]  el_s, es_s, dexp_s;
    logic [23:0] ml_s, ms_s;
    logic [49:0] ext_s;
    logic [26:0] large_s, small_s, diff_s, norm_s;
    logic [27:0] sum_s;
    logic [4:0]  lz_s;
    logic [9:0]  exp_n_s, exp_r_s;
    logic        rnd_up_s, cancel_s;
    logic [24:0] rnd_s;
    logic [22:0] frac_r_s;
    logic [31:0] result_d, result_q;
    logic        overflow_d, overflow_q, underflow_d, underflow_q;

    // Align, add/subtract, normalize and round the two finite operands.
    always_comb begin
        swap_s  = {eb_s, fb_s} > {ea_s, fa_s};
        sl_s    = swap_s ? sb_s : sa_s;
        el_s    = swap_s ? eb_s : ea_s;
        es_s    = swap_s ? ea_s : eb_s;
        ml_s    = {1'b1, (swap_s ? fb_s : fa_s)};
        ms_s    = {1'b1, (swap_s ? fa_s : fb_s)};
        dexp_s  = el_s - es_s;
        ext_s   = {ms_s, 26'd0} >> dexp_s;
        large_s = {ml_s, 3'b000};
        // Bits [25],[24] of the shifted value become guard/round; the rest folds into sticky.
        if (dexp_s >= 8'd26) begin
            small_s = 27'd1;
        end else begin
            small_s = {ext_s[49:24], |ext_s[23:0]};
        end
        sum_s    = 28'd0;
        diff_s   = 27'd0;
        lz_s     = 5'd0;
        cancel_s = 1'b0;
        if (sa_s == sb_s) begin
            sum_s = {1'b0, large_s} + {1'b0, small_s};
            if (sum_s[27]) begin
                norm_s  = {sum_s[27:2], sum_s[1] | sum_s[0]};
                exp_n_s = {2'b00, el_s} + 10'd1;
            end else begin
                norm_s  = sum_s[26:0];
                exp_n_s = {2'b00, el_s};
            end
        end else begin
            diff_s   = large_s - small_s;
            lz_s     = lzc27(diff_s);
            norm_s   = diff_s << lz_s;
            exp_n_s  = {2'b00, el_s} - {5'd0, lz_s};
            cancel_s = (diff_s == 27'd0);
        end
        rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s    = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
        if (rnd_s[24]) begin
            frac_r_s = rnd_s[23:1];
            exp_r_s  = exp_n_s + 10'd1;
        end else begin
            frac_r_s = rnd_s[22:0];
            exp_r_s  = exp_n_s;
        end
    end

    // Choose between special-operand results, range limits and the rounded sum.
    always_comb begin
        result_d    = {sl_s, exp_r_s[7:0], frac_r_s};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
            result_d = QNAN;
        end else if (a_inf_s) begin
            result_d = bus.data1;
        end else if (b_inf_s) begin
            result_d = bus.data2;
        end else if (a_zero_s && b_zero_s) begin
            result_d = {sa_s & sb_s, 31'd0};
        end else if (a_zero_s) begin
            result_d = bus.data2;
        end else if (b_zero_s) begin
            result_d = bus.data1;
        end else if (cancel_s) begin
            result_d = 32'h0000_0000;
        end else if (!exp_r_s[9] && (exp_r_s >= 10'd255)) begin
            result_d   = {sl_s, 8'hFF, 23'd0};
            overflow_d = 1'b1;
        end else if (exp_r_s[9] || (exp_r_s == 10'd0)) begin
            result_d    = {sl_s, 31'd0};
            underflow_d = 1'b1;
        end else begin
            result_d = {sl_s, exp_r_s[7:0], frac_r_s};
        end
    end

    // Output register; reset takes priority over operands sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= 32'h0000_0000;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fp32_adder.sv
// Bench for fp32_adder: fixed vector table, hand-written reset/pipeline sequences,
// and random operands checked against an exact wide-integer reference model.
module tb_fp32_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fp32_adder_if bus ();

    fp32_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] res_exp,
                         input logic ovf_exp, input logic unf_exp);
        n_vec++;
        if ({bus.overflow, bus.underflow, bus.result} !== {ovf_exp, unf_exp, res_exp}) begin
            n_err++;
            $display("FAIL %s: got result=%08h ovf=%0b unf=%0b, want result=%08h ovf=%0b unf=%0b",
                     name, bus.result, bus.overflow, bus.underflow, res_exp, ovf_exp, unf_exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        #1;
    endtask

    // Exact model: both operands become integers in units of 2^-149, are summed
    // exactly, then rounded to 24 significant bits with ties to even.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [283:0]        ma, mb, mag, keep, rem, half;
        logic signed [283:0] va, vb, sum;
        logic                a_nan, b_nan, a_inf, b_inf, s, found;
        int                  p, sh, e;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) return {2'b00, 32'h7FC0_0000};
        if (a_inf && b_inf) return (a[31] != b[31]) ? {2'b00, 32'h7FC0_0000} : {2'b00, a};
        if (a_inf) return {2'b00, a};
        if (b_inf) return {2'b00, b};
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {2'b00, a[31] & b[31], 31'd0};
        ma = '0;
        mb = '0;
        if (a[30:23] != 8'd0) begin
            ma[23:0] = {1'b1, a[22:0]};
            ma = ma << (a[30:23] - 8'd1);
        end
        if (b[30:23] != 8'd0) begin
            mb[23:0] = {1'b1, b[22:0]};
            mb = mb << (b[30:23] - 8'd1);
        end
        va  = a[31] ? -$signed(ma) : $signed(ma);
        vb  = b[31] ? -$signed(mb) : $signed(mb);
        sum = va + vb;
        if (sum == 0) return {2'b00, 32'h0000_0000};
        s     = sum[283];
        mag   = s ? 284'(-sum) : 284'(sum);
        p     = 0;
        found = 1'b0;
        for (int i = 283; i >= 0; i--) begin
            if (!found && mag[i]) begin
                p     = i;
                found = 1'b1;
            end
        end
        if (p < 23) return {2'b01, s, 31'd0};
        sh   = p - 23;
        keep = mag >> sh;
        if (sh > 0) begin
            rem  = mag - (keep << sh);
            half = 284'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 284'd1;
        end
        if (keep[24]) begin
            keep = keep >> 1;
            sh   = sh + 1;
        end
        e = sh + 1;
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        return {2'b00, s, 8'(e), keep[22:0]};
    endfunction

    logic [31:0] ra, rb;
    logic [33:0] rexp;

    initial begin
        tbl.push_back('{32'h42C86666, 32'h42B50000, 32'h433EB333, 1'b0, 1'b0});
        tbl.push_back('{32'h4249999A, 32'h42C9999A, 32'h43173334, 1'b0, 1'b0});
        tbl.push_back('{32'hC3F6E666, 32'hC376E666, 32'hC4392CCC, 1'b0, 1'b0});
        tbl.push_back('{32'hC2ACFAE1, 32'hC4163852, 32'hC42BD7AE, 1'b0, 1'b0});
        tbl.push_back('{32'h42C86666, 32'hC2B50000, 32'h411B3330, 1'b0, 1'b0});
        tbl.push_back('{32'hC2C86666, 32'h42B50000, 32'hC11B3330, 1'b0, 1'b0});
        tbl.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0});
        tbl.push_back('{32'h00800001, 32'h80800000, 32'h00000000, 1'b0, 1'b1});
        tbl.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0});
        tbl.push_back('{32'h7F800000, 32'hC0000000, 32'h7F800000, 1'b0, 1'b0});
        tbl.push_back('{32'hFF800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0});
        tbl.push_back('{32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800000, 32'h80000000, 32'h3F800000, 1'b0, 1'b0});
        tbl.push_back('{32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0});
        tbl.push_back('{32'h3F800000, 32'h00800000, 32'h3F800000, 1'b0, 1'b0});
        tbl.push_back('{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b1, 1'b0});
        tbl.push_back('{32'h00800000, 32'h00800000, 32'h01000000, 1'b0, 1'b0});
        tbl.push_back('{32'h00800000, 32'h80000001, 32'h00800000, 1'b0, 1'b0});

        // Reset with live operands present: outputs must be zero.
        rst       = 1'b1;
        bus.data1 = 32'h7F7FFFFF;
        bus.data2 = 32'h7F7FFFFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].a, tbl[i].b);
            check($sformatf("table[%0d]", i), tbl[i].res, tbl[i].ovf, tbl[i].unf);
        end

        // Overflow result, then rst on the same edge as a new operand pair.
        apply(32'h7F7FFFFF, 32'h7F7FFFFF);
        check("ovf_before_rst", 32'h7F800000, 1'b1, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        bus.data1 = 32'h3F800000;
        bus.data2 = 32'h3F800000;
        @(posedge clk);
        #1;
        check("rst_same_edge", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ops: each result appears after one edge and holds until the next.
        apply(32'h3F800000, 32'h40000000);
        check("b2b_0", 32'h40400000, 1'b0, 1'b0);
        apply(32'h40400000, 32'hBF800000);
        check("b2b_1", 32'h40000000, 1'b0, 1'b0);
        @(negedge clk);
        bus.data1 = 32'h00800001;
        bus.data2 = 32'h80800000;
        #1;
        check("b2b_hold", 32'h40000000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_2", 32'h00000000, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                1: begin
                    rb[30:23] = ra[30:23] + 8'($urandom_range(0, 3));
                end
                2: begin
                    rb        = ra ^ {1'b1, 23'd0, 8'($urandom_range(0, 255))};
                    rb[30:23] = ra[30:23] - 8'($urandom_range(0, 1));
                end
                3: begin
                    if ($urandom_range(0, 1) == 0) begin
                        ra[30:23] = 8'($urandom_range(250, 254));
                        rb[30:23] = 8'($urandom_range(250, 254));
                    end else begin
                        ra[30:23] = 8'($urandom_range(1, 4));
                        rb[30:23] = 8'($urandom_range(1, 4));
                    end
                end
                default: begin
                    rb = rb;
                end
            endcase
            rexp = ref_add(ra, rb);
            apply(ra, rb);
            check($sformatf("rand %08h+%08h", ra, rb), rexp[31:0], rexp[33], rexp[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
